system_pio_dataout: RTL and testbench
=====================================

# system_pio_dataout

Avalon-MM slave output PIO: the write-side counterpart of the system's input PIOs. Software writes 32-bit words into a small FIFO through the data register. The block presents them to fabric logic on a valid/ready stream port. Status, overflow and last-sent registers are readable with the same one-cycle registered read path the input PIOs use.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select: 0 DATA, 1 STATUS, 2 reserved, 3 LAST.
- chipselect  in  1  qualifies write.
- write  in  1  write strobe, active high; acts only with chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word.

## Operation
- CW = log2(DEPTH)+1 (count width).
- State:
  - FIFO storage;
  - rd_ptr and wr_ptr, log2(DEPTH) bits, wrapping modulo DEPTH;
  - count, CW bits;
  - ovf, 16-bit saturating counter;
  - last, 32 bits.
- push = chipselect & write & address==0.
- pop = out_valid & out_ready.
- flush = chipselect & write & address==1 & writedata[0].
- ovf_clr = chipselect & write & address==1 & writedata[1].
- Push when count<DEPTH: writedata is stored at wr_ptr, wr_ptr advances and count increments.
- Push when full with no pop in the same cycle: the word is dropped, nothing else changes, and ovf increments (saturates at 0xFFFF).
- Push and pop in the same cycle, including when full: both take effect and count is unchanged.
- Pop: last <= out_data, rd_ptr advances and count decrements.
- Flush: pointers and count go to 0 and stored words are discarded.
  - A pop in the same cycle still updates last.
  - ovf is untouched unless ovf_clr is also set.
- ovf_clr: ovf <= 0. If it coincides with an overflow event, the clear wins.
- Writes to addresses 2 and 3 have no effect.
- out_valid = (count != 0). out_data = FIFO[rd_ptr] when out_valid, else 0.
- Register map (read):
  - 0: FIFO head word, or 0 when empty. Reading does not pop.
  - 1: STATUS, made up of:
    - bit0 empty;
    - bit1 full;
    - bits[8+CW-1:8] count;
    - bits[31:16] ovf;
    - all other bits 0.
  - 2: always 0.
  - 3: last.
- Reset values:
  - readdata 0;
  - out_valid 0 and out_data 0;
  - count 0, pointers 0;
  - ovf 0;
  - last 0.

## Timing
- Reads:
  - readdata is registered every cycle from address; no read strobe is needed.
  - The value in cycle N+1 reflects the address and register state sampled in cycle N, i.e. before that cycle's updates.
  - Read latency is 1.
- Push in cycle N: out_valid rises in cycle N+1 if the FIFO was empty. Write-to-out_valid latency is 1 cycle, and there is no combinational path from writedata to out_data.
- Pop:
  - Takes effect at the edge ending cycle N.
  - The next word, or out_valid=0, is visible in cycle N+1.
  - Back-to-back pops sustain 1 word per cycle.
- out_valid must not drop while out_ready is low, except on flush or reset.
- out_data is stable while out_valid=1 and out_ready=0.
- Reset asserted mid-stream:
  - everything returns to reset values on the next edge;
  - a handshake in the reset cycle is ignored, so last is not updated.
- Pointer wrap: pointers roll from DEPTH-1 to 0. Fill/drain cycles must preserve order across the wrap.

## Test plan
- Reset with out_ready=0, then push 0x11, 0x22, 0x33 -> out_valid=1 one cycle after the first push, out_data=0x11. STATUS reads count=3, empty=0, full=0.
- out_ready=1 for 3 cycles -> out_data is 0x11, 0x22, 0x33 on successive cycles, then out_valid=0. LAST reads 0x33 and STATUS reads empty=1.
- DEPTH=4 with out_ready=0: push 6 words -> full=1, ovf=2, and the first 4 words drain in order. Write 0x2 to address 1 -> ovf=0.
- Full FIFO, out_ready=1, push 0xAA in the same cycle -> count stays 4, ovf unchanged, 0xAA drains 4th.
- Push 3 words, write 0x1 to address 1 -> next cycle out_valid=0 and count=0.
  - A then-push of 0x55 appears as the head one cycle later.
  - 10 fill/drain rounds across pointer wrap -> no reordering or loss.
- Reset asserted while count=2 and out_ready=1 -> next cycle out_valid=0, readdata=0, LAST=0, STATUS=0x00000001.

Source files
------------

// File: rtl/system_pio_dataout.sv
// Avalon-MM output PIO: software pushes 32-bit words into a small FIFO that
// drains onto a valid/ready stream; status, overflow and last-sent are readable.
module system_pio_dataout #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   ovf;
    logic [31:0]   last;

    logic        full;
    logic        empty;
    logic        reg_wr;
    logic        push;
    logic        pop;
    logic        flush;
    logic        ovf_clr;
    logic        push_acc;
    logic        ovf_evt;
    logic [31:0] status;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign reg_wr   = chipselect & write;
    assign push     = reg_wr & (address == 2'd0);
    assign flush    = reg_wr & (address == 2'd1) & writedata[0];
    assign ovf_clr  = reg_wr & (address == 2'd1) & writedata[1];
    assign pop      = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign push_acc = push & (~full | pop);
    assign ovf_evt  = push & full & ~pop;

    assign out_valid = ~empty;
    assign out_data  = out_valid ? mem[rd_ptr] : 32'd0;

    always_comb begin
        status        = 32'd0;
        status[0]     = empty;
        status[1]     = full;
        status[15:8]  = {{(8-CW){1'b0}}, count};
        status[31:16] = ovf;
    end

    // NOTE: storage has no reset; count/pointers define which entries are valid,
    // and leaving the array unreset lets it map onto plain RAM/flops without a reset net.
    always_ff @(posedge clk) begin
        if (!reset && push_acc)
            mem[wr_ptr] <= writedata;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= '0;
            last   <= '0;
        end else begin
            if (pop)
                last <= out_data;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push_acc)
                    wr_ptr <= wr_ptr + AW'(1);
                if (push_acc && !pop)
                    count <= count + CW'(1);
                else if (pop && !push_acc)
                    count <= count - CW'(1);
            end

            if (ovf_clr)
                ovf <= '0;
            else if (ovf_evt && ovf != 16'hFFFF)
                ovf <= ovf + 16'd1;
        end
    end

    // Read data reflects the address and register state before this edge's updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= out_data;
                2'd1:    readdata <= status;
                2'd3:    readdata <= last;
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_system_pio_dataout.sv
// Directed bench for system_pio_dataout: a table of per-cycle vectors with
// hand-computed results, plus a fill/drain loop across the pointer wrap.
module tb_system_pio_dataout;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    system_pio_dataout #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic rst, input logic cs, input logic wr, input logic [1:0] addr,
                     input logic [31:0] wdata, input logic rdy, input logic ev,
                     input logic [31:0] ed, input logic [31:0] er);
        vec_t t;
        t.rst = rst; t.cs = cs; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdy = rdy;
        t.exp_valid = ev; t.exp_data = ed; t.exp_rd = er;
        vecs.push_back(t);
    endtask

    // Apply inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic rst, input logic cs, input logic wr, input logic [1:0] addr,
                        input logic [31:0] wdata, input logic rdy);
        reset = rst; chipselect = cs; write = wr; address = addr;
        writedata = wdata; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = 2'd0;
        writedata = 32'd0; out_ready = 1'b0;

        //  rst cs wr addr wdata         rdy  valid data          readdata
        v(1, 0, 0, 0, 32'h0,          0,   0, 32'h0,          32'h0);         // 0 reset
        v(0, 1, 1, 0, 32'h11,         0,   1, 32'h11,         32'h0);         // 1 push
        v(0, 1, 1, 0, 32'h22,         0,   1, 32'h11,         32'h11);
        v(0, 1, 1, 0, 32'h33,         0,   1, 32'h11,         32'h11);
        v(0, 0, 0, 1, 32'h0,          0,   1, 32'h11,         32'h0000_0300); // 4 count=3
        v(0, 0, 0, 1, 32'h0,          1,   1, 32'h22,         32'h0000_0300); // 5 pop 11
        v(0, 0, 0, 1, 32'h0,          1,   1, 32'h33,         32'h0000_0200);
        v(0, 0, 0, 3, 32'h0,          1,   0, 32'h0,          32'h22);
        v(0, 0, 0, 3, 32'h0,          0,   0, 32'h0,          32'h33);        // 8 LAST
        v(0, 0, 0, 1, 32'h0,          0,   0, 32'h0,          32'h0000_0001); // 9 empty
        v(0, 1, 1, 0, 32'hA1,         0,   1, 32'hA1,         32'h0);         // 10 fill
        v(0, 1, 1, 0, 32'hA2,         0,   1, 32'hA1,         32'hA1);
        v(0, 1, 1, 0, 32'hA3,         0,   1, 32'hA1,         32'hA1);
        v(0, 1, 1, 0, 32'hA4,         0,   1, 32'hA1,         32'hA1);
        v(0, 1, 1, 0, 32'hA5,         0,   1, 32'hA1,         32'hA1);        // 14 drop
        v(0, 1, 1, 0, 32'hA6,         0,   1, 32'hA1,         32'hA1);        // 15 drop
        v(0, 0, 0, 1, 32'h0,          0,   1, 32'hA1,         32'h0002_0402); // 16 ovf=2 full
        v(0, 1, 1, 1, 32'h2,          0,   1, 32'hA1,         32'h0002_0402); // 17 ovf_clr
        v(0, 0, 0, 1, 32'h0,          0,   1, 32'hA1,         32'h0000_0402);
        v(0, 1, 1, 0, 32'hAA,         1,   1, 32'hA2,         32'hA1);        // 19 push+pop full
        v(0, 0, 0, 1, 32'h0,          0,   1, 32'hA2,         32'h0000_0402);
        v(0, 0, 0, 3, 32'h0,          1,   1, 32'hA3,         32'hA1);
        v(0, 0, 0, 3, 32'h0,          1,   1, 32'hA4,         32'hA2);
        v(0, 0, 0, 3, 32'h0,          1,   1, 32'hAA,         32'hA3);
        v(0, 0, 0, 3, 32'h0,          1,   0, 32'h0,          32'hA4);
        v(0, 0, 0, 3, 32'h0,          0,   0, 32'h0,          32'hAA);        // 25
        v(0, 1, 1, 0, 32'h01,         0,   1, 32'h01,         32'h0);
        v(0, 1, 1, 0, 32'h02,         0,   1, 32'h01,         32'h01);
        v(0, 1, 1, 0, 32'h03,         0,   1, 32'h01,         32'h01);
        v(0, 1, 1, 1, 32'h1,          0,   0, 32'h0,          32'h0000_0300); // 29 flush
        v(0, 1, 1, 0, 32'h55,         0,   1, 32'h55,         32'h0);
        v(0, 0, 0, 1, 32'h0,          0,   1, 32'h55,         32'h0000_0100);
        v(0, 0, 0, 0, 32'h0,          1,   0, 32'h0,          32'h55);
        v(0, 1, 1, 0, 32'h66,         0,   1, 32'h66,         32'h0);         // 33
        v(0, 1, 1, 0, 32'h77,         0,   1, 32'h66,         32'h66);
        v(1, 0, 0, 3, 32'h0,          1,   0, 32'h0,          32'h0);         // 35 reset mid-stream
        v(0, 0, 0, 3, 32'h0,          0,   0, 32'h0,          32'h0);
        v(0, 0, 0, 1, 32'h0,          0,   0, 32'h0,          32'h0000_0001);
        v(0, 1, 1, 0, 32'h88,         0,   1, 32'h88,         32'h0);         // 38
        v(0, 1, 1, 0, 32'h99,         0,   1, 32'h88,         32'h88);
        v(0, 1, 1, 1, 32'h1,          1,   0, 32'h0,          32'h0000_0200); // 40 flush+pop
        v(0, 0, 0, 3, 32'h0,          0,   0, 32'h0,          32'h88);
        v(0, 1, 1, 2, 32'hDEAD,       0,   0, 32'h0,          32'h0);         // 42 reserved write
        v(0, 0, 0, 1, 32'h0,          0,   0, 32'h0,          32'h0000_0001);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
            check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d out_data", i), out_data, vecs[i].exp_data);
            check($sformatf("v%0d readdata", i), readdata, vecs[i].exp_rd);
        end

        // Fill/drain rounds of varying length walk the pointers across the wrap.
        for (int r = 0; r < 10; r++) begin
            int n;
            n = (r % 4) + 1;
            for (int k = 0; k < n; k++)
                step(0, 1, 1, 2'd0, 32'hC000_0000 | (r << 8) | k, 0);
            for (int k = 0; k < n; k++) begin
                check($sformatf("wrap r%0d k%0d valid", r, k), {31'd0, out_valid}, 32'd1);
                check($sformatf("wrap r%0d k%0d data", r, k), out_data, 32'hC000_0000 | (r << 8) | k);
                step(0, 0, 0, 2'd0, 32'h0, 1);
            end
            check($sformatf("wrap r%0d drained", r), {31'd0, out_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
